vector_stream_assembler: RTL and testbench
==========================================

VECTOR_STREAM_ASSEMBLER -- requirements
Module: vector_stream_assembler

Interface
REQ-001 Parameter SCALAR_BITS, default 32, SHALL set the width in bits of one scalar.
REQ-002 Parameter LENGTH, default 5, SHALL set the number of scalars per vector; legal range is 2 or more.
REQ-003 Derived constants SHALL be INDEX_WIDTH = $clog2(LENGTH) and SIZE_BITS = LENGTH*SCALAR_BITS.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-005 Port list SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  assembler accepts a scalar this cycle
- in_data  input  SCALAR_BITS  scalar (spectral band sample)
- in_last  input  1  marks final scalar of a vector
- out_valid  output  1  out_vector complete and stable
- out_ready  input  1  consumer loads out_vector this cycle
- out_vector  output  SIZE_BITS  assembled vector
- frame_error  output  1  one-cycle pulse on in_last misalignment
- vec_count  output  16  completed-vector counter

Function
REQ-006 A scalar SHALL be accepted on each clk edge where in_valid && in_ready.
REQ-007 The k-th accepted scalar of a vector (k = 0..LENGTH-1) SHALL be written to out_vector[k*SCALAR_BITS +: SCALAR_BITS]; index 0 is the LSB slice.
REQ-008 State SHALL be FILL or FULL.
- FILL: in_ready=1, out_valid=0.
- FULL: in_ready=0, out_valid=1.
REQ-009 In FILL, an accepted scalar SHALL increment the write index.
- Accepting the scalar at index LENGTH-1 SHALL move to FULL on the same edge.
- out_valid SHALL rise the cycle after that last accept (latency 1 from last accept).
REQ-010 In FULL, out_valid && out_ready SHALL return to FILL with index 0 and increment vec_count.
- in_ready SHALL rise the following cycle; there is no same-cycle fill-through.
REQ-011 out_vector SHALL hold unchanged while out_valid=1, and SHALL NOT change until new scalars are accepted.
REQ-012 out_valid, once asserted, SHALL stay high until out_ready is sampled high.
REQ-013 An accepted scalar with in_last=1 at index < LENGTH-1 SHALL:
- pulse frame_error for one cycle;
- discard the partial vector;
- reset the index to 0 and remain in FILL.
REQ-014 An accepted scalar at index LENGTH-1 with in_last=0 SHALL pulse frame_error and still complete the vector into FULL.
REQ-015 vec_count SHALL wrap from 65535 to 0.
REQ-016 in_valid=1 while in_ready=0 SHALL have no effect, and the scalar SHALL NOT be consumed.
REQ-017 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-018 With rst=1 at a clk edge, the block SHALL set state FILL, index 0, out_valid 0, in_ready 1 (from the next cycle), frame_error 0, vec_count 0, out_vector 0.
REQ-019 rst SHALL have priority over all handshakes; a partial vector or an unconsumed FULL vector SHALL be discarded.

Structure
REQ-020 The FILL/FULL state enum typedef SHALL reside in the shared lcmv_pkg package; SCALAR_BITS/LENGTH remain module parameters.
REQ-021 No sub-module SHALL be instantiated; the index counter, vec_count and data register SHALL be inline.
REQ-022 out_vector SHALL connect directly to the in port of the downstream vector register, with out_valid && out_ready driving its load.

Verification (LENGTH=5, SCALAR_BITS=32)
REQ-023 The bench SHALL cover the following directed scenarios:
- Normal vector: stream 0x11,0x22,0x33,0x44,0x55 back-to-back, in_last on 5th, out_ready=0 -> out_valid rises next cycle; out_vector = {0x55,0x44,0x33,0x22,0x11} (MSB..LSB); in_ready=0; vector held 10 cycles.
- Handshake release: then out_ready=1 one cycle -> vec_count=1, out_valid=0, in_ready=1 next cycle; two further vectors -> vec_count=3.
- Early last: in_last on the 3rd scalar -> frame_error pulses once; the next 5 scalars 0xA0..0xA4 form out_vector with 0xA0 at LSB.
- Missing last: 5 scalars with in_last=0 -> frame_error pulse and out_valid=1.
- Back-pressure: in_valid held high during FULL -> no scalar lost; the held scalar lands at index 0 after release.
- Reset mid-operation: rst after 2 scalars, and again in FULL -> out_valid=0, vec_count=0, index 0; the next full vector assembles correctly.

Source files
------------

// File: rtl/lcmv_pkg.sv
// Shared types for the LCMV datapath: vector assembler FSM states.
package lcmv_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } asm_state_e;

endpackage

// File: rtl/vector_stream_assembler.sv
// Packs LENGTH scalars into one vector; out_valid one cycle after the last accept.
// in_ready is low while a full vector waits for out_ready; no fill-through on release.
module vector_stream_assembler
  import lcmv_pkg::*;
#(
  parameter int SCALAR_BITS = 32,
  parameter int LENGTH      = 5,
  localparam int INDEX_WIDTH = $clog2(LENGTH),
  localparam int SIZE_BITS   = LENGTH * SCALAR_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SCALAR_BITS-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE_BITS-1:0]   out_vector,
  output logic                   frame_error,
  output logic [15:0]            vec_count
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(LENGTH - 1);

  asm_state_e                           state_q, state_d;
  logic [INDEX_WIDTH-1:0]               idx_q, idx_d;
  logic                                 fe_d;
  logic [15:0]                          cnt_d;
  logic                                 load;
  logic [LENGTH-1:0][SCALAR_BITS-1:0]   data_q;

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == FULL);
  assign out_vector = data_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fe_d    = 1'b0;
    cnt_d   = vec_count;
    load    = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          load = 1'b1;
          if (idx_q == LAST_IDX) begin
            // A missing in_last is flagged but the vector still completes.
            state_d = FULL;
            idx_d   = '0;
            fe_d    = !in_last;
          end else if (in_last) begin
            idx_d = '0;
            fe_d  = 1'b1;
          end else begin
            idx_d = idx_q + INDEX_WIDTH'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
          cnt_d   = vec_count + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      frame_error <= 1'b0;
      vec_count   <= 16'd0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_error <= fe_d;
      vec_count   <= cnt_d;
      // Slices of a discarded partial vector are simply overwritten by the next one.
      if (load) data_q[idx_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_vector_stream_assembler.sv
// Directed bench for vector_stream_assembler with a scoreboard of expected vectors.
module tb_vector_stream_assembler;

  localparam int SB  = 32;
  localparam int LEN = 5;
  localparam int SZ  = SB * LEN;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SB-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [SZ-1:0] out_vector;
  logic          frame_error;
  logic [15:0]   vec_count;

  vector_stream_assembler #(.SCALAR_BITS(SB), .LENGTH(LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vector  (out_vector),
    .frame_error (frame_error),
    .vec_count   (vec_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            passes = 0;
  logic [SZ-1:0] sb_q[$];
  logic [15:0]   exp_cnt;

  task automatic chk(input string tag, input logic [SZ-1:0] obs, input logic [SZ-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SZ-1:0] vec_of(input logic [SB-1:0] base);
    logic [SZ-1:0] r;
    for (int k = 0; k < LEN; k++) r[k*SB +: SB] = base + SB'(k);
    return r;
  endfunction

  task automatic send(input logic [SB-1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("send_timeout_in_ready", SZ'(in_ready), SZ'(1));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [SB-1:0] base);
    sb_q.push_back(vec_of(base));
    for (int k = 0; k < LEN; k++) send(base + SB'(k), k == LEN - 1);
  endtask

  task automatic release_out(input string tag);
    chk({tag, "_valid_before"}, SZ'(out_valid), SZ'(1));
    if (sb_q.size() > 0) chk({tag, "_vector"}, out_vector, sb_q.pop_front());
    else chk({tag, "_sb_empty"}, SZ'(out_valid), SZ'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_valid_after"}, SZ'(out_valid), SZ'(0));
    chk({tag, "_in_ready_after"}, SZ'(in_ready), SZ'(1));
    chk({tag, "_vec_count"}, SZ'(vec_count), SZ'(exp_cnt));
  endtask

  initial begin
    logic [SZ-1:0] exp_v;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    exp_cnt = 16'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", SZ'(out_valid), SZ'(0));
    chk("rst_in_ready", SZ'(in_ready), SZ'(1));
    chk("rst_vec_count", SZ'(vec_count), SZ'(0));
    chk("rst_frame_error", SZ'(frame_error), SZ'(0));
    chk("rst_out_vector", out_vector, SZ'(0));

    // Normal vector, held 10 cycles without out_ready.
    exp_v = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    sb_q.push_back(exp_v);
    send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0); send(32'h44, 1'b0);
    chk("norm_not_valid_early", SZ'(out_valid), SZ'(0));
    send(32'h55, 1'b1);
    chk("norm_out_valid", SZ'(out_valid), SZ'(1));
    chk("norm_in_ready", SZ'(in_ready), SZ'(0));
    chk("norm_vector", out_vector, exp_v);
    chk("norm_no_fe", SZ'(frame_error), SZ'(0));
    repeat (10) tick();
    chk("norm_hold_valid", SZ'(out_valid), SZ'(1));
    chk("norm_hold_vector", out_vector, exp_v);
    release_out("norm_rel");

    // out_ready during FILL is ignored.
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("idle_ready_count", SZ'(vec_count), SZ'(exp_cnt));
    chk("idle_ready_in_ready", SZ'(in_ready), SZ'(1));
    chk("idle_ready_vector_kept", out_vector, exp_v);

    send_vec(32'h100); release_out("v2");
    send_vec(32'h200); release_out("v3");
    chk("three_vectors", SZ'(vec_count), SZ'(3));

    // Early in_last on the third scalar.
    send(32'h1, 1'b0); send(32'h2, 1'b0); send(32'h3, 1'b1);
    chk("early_fe", SZ'(frame_error), SZ'(1));
    chk("early_not_full", SZ'(out_valid), SZ'(0));
    tick();
    chk("early_fe_pulse", SZ'(frame_error), SZ'(0));
    send_vec(32'hA0);
    chk("early_next_no_fe", SZ'(frame_error), SZ'(0));
    release_out("early_rel");

    // Missing in_last.
    sb_q.push_back(vec_of(32'hC0));
    for (int k = 0; k < LEN; k++) send(32'hC0 + SB'(k), 1'b0);
    chk("miss_fe", SZ'(frame_error), SZ'(1));
    chk("miss_out_valid", SZ'(out_valid), SZ'(1));
    tick();
    chk("miss_fe_pulse", SZ'(frame_error), SZ'(0));
    release_out("miss_rel");

    // Back-pressure: in_valid held through FULL.
    send_vec(32'hD0);
    sb_q.push_back(vec_of(32'hB0));
    in_valid = 1'b1; in_data = 32'hB0; in_last = 1'b0;
    repeat (3) tick();
    chk("bp_in_ready", SZ'(in_ready), SZ'(0));
    chk("bp_vector_held", out_vector, vec_of(32'hD0));
    release_out("bp_rel");
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < LEN; k++) send(32'hB0 + SB'(k), k == LEN - 1);
    release_out("bp_after");

    // Reset mid-fill, then in FULL.
    send(32'hE0, 1'b0); send(32'hE1, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    exp_cnt = 16'd0;
    chk("rstp_out_valid", SZ'(out_valid), SZ'(0));
    chk("rstp_vec_count", SZ'(vec_count), SZ'(0));
    chk("rstp_in_ready", SZ'(in_ready), SZ'(1));
    chk("rstp_out_vector", out_vector, SZ'(0));
    send_vec(32'hF0);
    chk("rstf_full", SZ'(out_valid), SZ'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    sb_q.delete();
    chk("rstf_out_valid", SZ'(out_valid), SZ'(0));
    chk("rstf_vec_count", SZ'(vec_count), SZ'(0));
    send_vec(32'h70);
    release_out("rst_after");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
